timer_sched: RTL
================

# timer_sched

Round-robin scheduler that shares one 16-bit elapsed-time counter among NREQ requesters. Each requester asks for a timeout of a given duration. The scheduler grants the counter to one requester at a time, clears and runs it, and pulses that requester's done when the duration elapses. It sits between the control FSMs that need delays and the timing datapath, replacing per-FSM private timers.

## Interface
- NREQ, 4: number of requesters, 2..8
- W, 16: counter and duration width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req  in  NREQ  per-requester level request; held high until done or to abort
- dur  in  NREQ*W  flattened durations; requester i uses bits [i*W +: W]
- gnt  out  NREQ  one-hot grant, high from CLEAR through DONE; reset 0
- done  out  NREQ  one-hot, one-cycle pulse on expiry; reset 0
- busy  out  1  high in any state other than IDLE; reset 0
- cur_id  out  $clog2(NREQ)  index of the granted requester, held after completion; reset 0
- elapsed  out  W  live counter value; reset 0

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE
  - If any req bit is high, pick the winner round-robin, starting at index ptr and searching upward with wrap.
  - Latch the winner index into cur_id and latch its dur slice into dur_q.
  - Go to CLEAR.
  - With no request, stay in IDLE.
- CLEAR
  - Synchronous clear of the counter to 0.
  - Go to RUN.
  - If req[cur_id] is low, go to IDLE instead (abort).
- RUN
  - Counter enable = (count != dur_q); the counter increments by 1 per enabled cycle.
  - When count == dur_q, the enable is low and the next state is DONE.
- DONE
  - done[cur_id] = 1 for exactly one cycle.
  - ptr <= cur_id + 1, modulo NREQ.
  - Go to IDLE.
- Abort
  - Applies whenever req[cur_id] is low in CLEAR or RUN.
  - Next state is IDLE, with no done pulse.
  - ptr <= cur_id + 1, modulo NREQ.
  - The counter holds its value.
- dur is sampled only on the IDLE→CLEAR transition; later changes to dur are ignored until the next grant.
- The counter never wraps, because it stops at dur_q ≤ 2^W−1.
- dur = 0 is legal and yields the minimum latency.
- Requests from non-granted requesters are ignored until the FSM returns to IDLE.
- A requester whose req is still high in the IDLE cycle after its done is treated as a new request. ptr has already moved past it, so other requesters win first.
- Reset mid-operation: every output, the counter and ptr go to 0 immediately. After release, the FSM is in IDLE and requester 0 has first priority.

## Timing
- Cycle 0: the FSM is in IDLE and req is sampled high.
- Cycle 1: CLEAR; gnt and busy go high.
- Cycle 2: RUN with count = 0.
- Cycle 2+D: RUN with count = D; the enable is low in this cycle.
- Cycle 3+D: DONE; done is high.
- Cycle 4+D: IDLE; gnt and busy are low.
- Latency from request to done is D+3 cycles.
- Back-to-back grants: minimum gap of one IDLE cycle between a DONE and the next CLEAR.
- Abort precedence: if req[cur_id] drops in the same cycle that count == dur_q, abort wins. There is no done pulse and the next state is IDLE.
- elapsed equals the registered count.

## Structure
- Package sched_pkg holds:
  - state encoding constants S_IDLE, S_CLEAR, S_RUN, S_DONE (2-bit);
  - default constants NREQ_DEF = 4 and W_DEF = 16.
- Sub-module rr_arbiter, combinational.
  - Inputs: req[NREQ], ptr.
  - Outputs: valid and a winner index.
  - Used only in IDLE.
- The FSM, counter, dur_q, cur_id and ptr live in timer_sched.

## Test plan
- Single request: req[1] = 1 with dur = 5 at cycle 0 → gnt = 0010 from cycle 1; done[1] pulses at cycle 8 only; elapsed = 5 at done.
- Zero duration: req[2] with dur = 0 → done[2] at cycle 3; busy low at cycle 4.
- Fairness: req = 1111, all dur = 2, each requester drops its req on its done → grant order 0, 1, 2, 3, 0; each done is 5 cycles after its IDLE cycle.
- Abort: req[0] with dur = 100; req[0] dropped at cycle 20 → no done pulse; busy low at cycle 21; ptr = 1, so a concurrent req[0] and req[1] grants 1 next.
- Reset mid-RUN: assert reset low at cycle 10 of a dur = 50 run → gnt, done, busy, elapsed and cur_id are all 0 asynchronously; after release with req = 1001, requester 0 wins.
- Late dur change and maximum duration: grant with dur = 0xFFFF, then change dur to 3 in cycle 2 → done is still at cycle 0xFFFF + 3; elapsed reaches 0xFFFF and does not wrap.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the round-robin timeout scheduler.
package sched_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/timer_sched.sv
// One shared elapsed-time counter handed round-robin to NREQ timeout requesters.
module timer_sched
  import sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       dur,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] cur_id,
  output logic [W-1:0]            elapsed
);
  localparam int IDW = $clog2(NREQ);

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, dur_q;
  logic [IDW-1:0] ptr, ptr_inc, win;
  logic           win_vld, req_cur;
  logic           cnt_clr, cnt_en, adv_ptr;
  logic [NREQ-1:0] sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .valid  (win_vld),
    .winner (win)
  );

  assign req_cur = req[cur_id];
  assign ptr_inc = (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + IDW'(1);

  // Dropping req on the granted slot aborts; it takes precedence over expiry.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    adv_ptr   = 1'b0;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (!req_cur) begin
          state_nxt = S_IDLE;
          adv_ptr   = 1'b1;
        end else begin
          cnt_clr   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!req_cur) begin
          state_nxt = S_IDLE;
          adv_ptr   = 1'b1;
        end else if (cnt == dur_q) begin
          state_nxt = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        adv_ptr   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dur_q  <= '0;
      cur_id <= '0;
      ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_vld) begin
        cur_id <= win;
        dur_q  <= dur[int'(win)*W +: W];
      end
      if (cnt_clr)     cnt <= '0;
      else if (cnt_en) cnt <= cnt + W'(1);
      if (adv_ptr) ptr <= ptr_inc;
    end
  end

  assign sel     = NREQ'(1) << cur_id;
  assign busy    = (state != S_IDLE);
  assign gnt     = busy ? sel : '0;
  assign done    = (state == S_DONE) ? sel : '0;
  assign elapsed = cnt;
endmodule
